// File: rtl/led_div_pkg.sv
// Shared types and helpers for the led_div_seq divide-value sequencer.
package led_div_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DWELL   = 2'd1,
    ISSUE   = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  localparam int DIV_W_DEF = 5;

  // Ping-pong step between min_v and max_v. Returns {dir, div} at 32-bit
  // width; the caller keeps only the low DIV_W bits of the value.
  function automatic logic [32:0] next_div(input logic [31:0] div,
                                           input logic        dir,
                                           input logic [31:0] min_v,
                                           input logic [31:0] max_v);
    logic [32:0] r;
    if (min_v == max_v)             r = {dir, div};
    else if (dir && div == max_v)   r = {1'b0, max_v - 32'd1};
    else if (!dir && div == min_v)  r = {1'b1, min_v + 32'd1};
    else if (dir)                   r = {1'b1, div + 32'd1};
    else                            r = {1'b0, div - 32'd1};
    return r;
  endfunction

endpackage

// File: rtl/led_div_seq_step_sync_db.sv
// Step button front end: 2-flop synchronizer, optional debouncer
// (LED_DIV_DEBOUNCE_EN) and registered rising-edge detect.
module step_sync_db #(
  parameter int DB_CYC = 1000000
) (
  input  logic clk100,
  input  logic rst,
  input  logic step_i,
  output logic step_pulse_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic lvl_prev_q, lvl_prev_d;
  logic pulse_q, pulse_d;
  logic lvl;

`ifdef LED_DIV_DEBOUNCE_EN
  localparam int DBW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYC - 1);

  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           db_lvl_q, db_lvl_d;

  // Count consecutive cycles the input disagrees with the held level
  always_comb begin
    db_cnt_d = '0;
    db_lvl_d = db_lvl_q;
    if (sync2_q != db_lvl_q) begin
      if (db_cnt_q == DB_LAST) db_lvl_d = sync2_q;
      else                     db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Debounce state
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      db_cnt_q <= '0;
      db_lvl_q <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      db_lvl_q <= db_lvl_d;
    end
  end

  assign lvl = db_lvl_q;
`else
  localparam int db_cyc_unused = DB_CYC;
  assign lvl = sync2_q;
`endif

  // Synchronizer shift and edge-detect next values
  always_comb begin
    sync1_d    = step_i;
    sync2_d    = sync1_q;
    lvl_prev_d = lvl;
    pulse_d    = lvl & ~lvl_prev_q;
  end

  // Synchronizer and edge-detect flops
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      lvl_prev_q <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      lvl_prev_q <= lvl_prev_d;
      pulse_q    <= pulse_d;
    end
  end

  assign step_pulse_o = pulse_q;

endmodule

// File: rtl/led_div_seq.sv
// Divide-value sequencer feeding led_cnt: issues one-cycle write strobes
// with a ping-pong divide value, from a dwell timer or a step button.
// Optional step debouncer enabled by defining LED_DIV_DEBOUNCE_EN.
module led_div_seq
  import led_div_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DIV_MIN     = 1,
  parameter int DIV_MAX     = 31,
  parameter int DWELL_CYC   = 100000000,
  parameter int HOLDOFF_CYC = 4,
  parameter int DB_CYC      = 1000000
) (
  input  logic             clk100,
  input  logic             rst,
  input  logic             en_i,
  input  logic             step_i,
  output logic [DIV_W-1:0] div_o,
  output logic             wren_o,
  output logic             dir_o,
  output logic             busy_o
);

  if (DIV_MIN < 1) begin : g_chk_min
    $fatal(1, "led_div_seq: DIV_MIN must be >= 1");
  end
  if (DIV_MIN > DIV_MAX) begin : g_chk_order
    $fatal(1, "led_div_seq: DIV_MIN must be <= DIV_MAX");
  end
  if (DIV_MAX >= (2 ** DIV_W)) begin : g_chk_max
    $fatal(1, "led_div_seq: DIV_MAX must fit in DIV_W bits");
  end

  localparam int TW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam int HW = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(DWELL_CYC - 1);
  localparam logic [HW-1:0] HO_LAST    = HW'(HOLDOFF_CYC - 1);

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [HW-1:0]    ho_q, ho_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             dir_q, dir_d;
  logic             wren_q, wren_d;
  logic             busy_q, busy_d;
  logic             step_pulse;
  logic [32:0]      nd;
  logic             nd_unused;

  step_sync_db #(
    .DB_CYC(DB_CYC)
  ) u_step (
    .clk100      (clk100),
    .rst         (rst),
    .step_i      (step_i),
    .step_pulse_o(step_pulse)
  );

  assign nd        = next_div(32'(div_q), dir_q, 32'(DIV_MIN), 32'(DIV_MAX));
  assign nd_unused = ^nd[31:DIV_W];

  // State, timers and registered outputs
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      ho_q    <= '0;
      div_q   <= DIV_W'(DIV_MIN);
      dir_q   <= 1'b1;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ho_q    <= ho_d;
      div_q   <= div_d;
      dir_q   <= dir_d;
      wren_q  <= wren_d;
      busy_q  <= busy_d;
    end
  end

  // Next state: en_i low beats step_pulse, which beats dwell expiry
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ho_d    = ho_q;
    case (state_q)
      IDLE: begin
        if (step_pulse) begin
          state_d = ISSUE;
        end else if (en_i) begin
          state_d = DWELL;
          timer_d = '0;
        end
      end
      DWELL: begin
        if (!en_i) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (step_pulse || timer_q == TIMER_LAST) begin
          state_d = ISSUE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ISSUE: begin
        state_d = HOLDOFF;
        ho_d    = '0;
      end
      HOLDOFF: begin
        if (ho_q == HO_LAST) begin
          ho_d    = '0;
          timer_d = '0;
          state_d = en_i ? DWELL : IDLE;
        end else begin
          ho_d = ho_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so strobe and value land together
  always_comb begin
    div_d  = div_q;
    dir_d  = dir_q;
    wren_d = (state_d == ISSUE);
    busy_d = (state_d == ISSUE) || (state_d == HOLDOFF);
    if (state_d == ISSUE) begin
      div_d = nd[DIV_W-1:0];
      dir_d = nd[32];
    end
  end

  assign div_o  = div_q;
  assign wren_o = wren_q;
  assign dir_o  = dir_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_led_div_seq.sv
// Self-checking bench for led_div_seq: randomized and directed stimulus
// against a time-based reference model of the sequencer.
`timescale 1ns/1ps
module tb_led_div_seq;

  localparam int DIV_W       = 5;
  localparam int DIV_MIN     = 1;
  localparam int DIV_MAX     = 3;
  localparam int DWELL_CYC   = 8;
  localparam int HOLDOFF_CYC = 2;
  localparam int DB_CYC      = 4;
`ifdef LED_DIV_DEBOUNCE_EN
  localparam int DBL = DB_CYC;
`else
  localparam int DBL = 0;
`endif
  localparam int HIST = 8192;

  logic clk100 = 1'b0;
  logic rst    = 1'b1;
  logic en_i   = 1'b0;
  logic step_i = 1'b0;
  logic [DIV_W-1:0] div_o;
  logic wren_o, dir_o, busy_o;

  led_div_seq #(
    .DIV_W(DIV_W), .DIV_MIN(DIV_MIN), .DIV_MAX(DIV_MAX),
    .DWELL_CYC(DWELL_CYC), .HOLDOFF_CYC(HOLDOFF_CYC), .DB_CYC(DB_CYC)
  ) dut (
    .clk100(clk100), .rst(rst), .en_i(en_i), .step_i(step_i),
    .div_o(div_o), .wren_o(wren_o), .dir_o(dir_o), .busy_o(busy_o)
  );

  always #5 clk100 = ~clk100;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: absolute edge times since reset release
  int edge_n, issue_cnt, last_issue, dwell_start;
  bit samp  [HIST];
  bit lvl_h [HIST];
  logic [DIV_W-1:0] exp_div;
  logic exp_dir, exp_wren, exp_busy;

  function automatic bit s_at(int i);
    return (i >= 0) ? samp[i] : 1'b0;
  endfunction

  function automatic bit l_at(int i);
    return (i >= 0) ? lvl_h[i] : 1'b0;
  endfunction

  task automatic model_reset();
    edge_n = 0; issue_cnt = 0; last_issue = -100; dwell_start = -1;
    exp_div = DIV_W'(DIV_MIN); exp_dir = 1'b1; exp_wren = 1'b0; exp_busy = 1'b0;
  endtask

  task automatic model_edge();
    bit req, issue, v, ok;
    int p, r;
    if (edge_n >= HIST) begin
      $display("FAIL model_history edge=%0d limit=%0d", edge_n, HIST);
      $fatal(1, "history exhausted");
    end
    samp[edge_n] = step_i;
    if (DBL == 0) begin
      lvl_h[edge_n] = s_at(edge_n - 1);
    end else begin
      // level flips once the input has shown the other value DB_CYC times running
      v  = ~l_at(edge_n - 1);
      ok = 1'b1;
      for (int j = 0; j < DBL; j++) if (s_at(edge_n - 2 - j) != v) ok = 1'b0;
      lvl_h[edge_n] = ok ? v : l_at(edge_n - 1);
    end
    req   = l_at(edge_n - 2) & ~l_at(edge_n - 3);
    issue = 1'b0;
    if (edge_n > last_issue && edge_n <= last_issue + HOLDOFF_CYC) begin
      // strobe cycle and guard cycles: requests are dropped
    end else if (edge_n == last_issue + HOLDOFF_CYC + 1) begin
      dwell_start = en_i ? edge_n : -1;
    end else if (dwell_start < 0) begin
      if (req) issue = 1'b1;
      else if (en_i) dwell_start = edge_n;
    end else if (!en_i) begin
      dwell_start = -1;
    end else if (req || (edge_n - dwell_start) == DWELL_CYC) begin
      issue = 1'b1;
    end
    if (issue) begin
      last_issue  = edge_n;
      dwell_start = -1;
      issue_cnt++;
      r = DIV_MAX - DIV_MIN;
      if (r == 0) begin
        exp_div = DIV_W'(DIV_MIN);
      end else begin
        p = issue_cnt % (2 * r);
        exp_div = (p <= r) ? DIV_W'(DIV_MIN + p) : DIV_W'(DIV_MAX - (p - r));
        exp_dir = (p >= 1 && p <= r);
      end
    end
    exp_wren = issue;
    exp_busy = (edge_n >= last_issue && edge_n <= last_issue + HOLDOFF_CYC);
    edge_n++;
  endtask

  task automatic tick();
    @(posedge clk100);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    en_i = 1'b0; step_i = 1'b0; rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk100);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    en_i = 1'b0; step_i = 1'b0; rst = 1'b1;
    model_reset();
    repeat (5) @(posedge clk100);
    #1;
    if ({div_o, dir_o, wren_o, busy_o} !== {DIV_W'(DIV_MIN), 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_hold got div=%0d dir=%b wren=%b busy=%b want div=%0d dir=1 wren=0 busy=0",
               div_o, dir_o, wren_o, busy_o, DIV_MIN);
    end
    n_vec++;
    rst = 1'b0;
    repeat (50) begin
      tick();
      if ({div_o, dir_o, wren_o, busy_o} !== {exp_div, exp_dir, exp_wren, exp_busy}) begin
        n_err++;
        $display("FAIL reset_idle edge=%0d got %0d/%b/%b/%b want %0d/%b/%b/%b", edge_n - 1,
                 div_o, dir_o, wren_o, busy_o, exp_div, exp_dir, exp_wren, exp_busy);
      end
      n_vec++;
    end
    $display("reset: %0d idle cycles checked, div=%0d", 50, div_o);
  endtask

  task automatic test_auto_sweep();
    int w_edge[$];
    int w_div[$];
    bit w_dir[$];
    int seq[6];
    bit dirs[6];
    seq  = '{2, 3, 2, 1, 2, 3};
    dirs = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    en_i = 1'b1;
    repeat (70) begin
      tick();
      if ({div_o, dir_o, wren_o, busy_o} !== {exp_div, exp_dir, exp_wren, exp_busy}) begin
        n_err++;
        $display("FAIL auto_cycle edge=%0d got %0d/%b/%b/%b want %0d/%b/%b/%b", edge_n - 1,
                 div_o, dir_o, wren_o, busy_o, exp_div, exp_dir, exp_wren, exp_busy);
      end
      n_vec++;
      if (wren_o === 1'b1) begin
        w_edge.push_back(edge_n - 1); w_div.push_back(int'(div_o)); w_dir.push_back(dir_o);
        $display("auto: wren at edge %0d div=%0d dir=%b", edge_n - 1, div_o, dir_o);
      end
    end
    if (w_edge.size() != 6) begin
      n_err++;
      $display("FAIL auto_count got %0d strobes want 6", w_edge.size());
    end
    n_vec++;
    if (w_edge.size() > 0) begin
      if (w_edge[0] != DWELL_CYC) begin
        n_err++;
        $display("FAIL auto_first got edge %0d want %0d", w_edge[0], DWELL_CYC);
      end
      n_vec++;
    end
    for (int i = 0; i < w_edge.size() && i < 6; i++) begin
      if (w_div[i] != seq[i] || w_dir[i] != dirs[i]) begin
        n_err++;
        $display("FAIL auto_seq idx=%0d got div=%0d dir=%b want div=%0d dir=%b",
                 i, w_div[i], w_dir[i], seq[i], dirs[i]);
      end
      n_vec++;
      if (i > 0 && (w_edge[i] - w_edge[i-1]) != 1 + HOLDOFF_CYC + DWELL_CYC) begin
        n_err++;
        $display("FAIL auto_period idx=%0d got %0d want %0d", i,
                 w_edge[i] - w_edge[i-1], 1 + HOLDOFF_CYC + DWELL_CYC);
      end
      if (i > 0) n_vec++;
    end
  endtask

  task automatic test_manual_step();
    int wcount = 0;
    int wedge  = -1;
    int bcount = 0;
    do_reset();
    step_i = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (c == 4) step_i = 1'b0;
      if ({div_o, dir_o, wren_o, busy_o} !== {exp_div, exp_dir, exp_wren, exp_busy}) begin
        n_err++;
        $display("FAIL step_cycle edge=%0d got %0d/%b/%b/%b want %0d/%b/%b/%b", edge_n - 1,
                 div_o, dir_o, wren_o, busy_o, exp_div, exp_dir, exp_wren, exp_busy);
      end
      n_vec++;
      if (wren_o === 1'b1) begin wcount++; wedge = edge_n - 1; end
      if (busy_o === 1'b1) bcount++;
    end
    $display("step: %0d strobe(s), last at edge %0d, busy %0d cycles, div=%0d", wcount, wedge, bcount, div_o);
    if (wcount != 1 || wedge != 3 + DBL) begin
      n_err++;
      $display("FAIL step_strobe got count=%0d edge=%0d want count=1 edge=%0d", wcount, wedge, 3 + DBL);
    end
    n_vec++;
    if (bcount != 1 + HOLDOFF_CYC || div_o !== DIV_W'(2)) begin
      n_err++;
      $display("FAIL step_busy got busy=%0d div=%0d want busy=%0d div=2", bcount, div_o, 1 + HOLDOFF_CYC);
    end
    n_vec++;
  endtask

  task automatic test_step_interactions();
    int wcount = 0;
    int w_edge[$];
    // step pulses at edge 0 and edges 2..3: the second lands in the guard window
    do_reset();
    step_i = 1'b1;
    for (int c = 0; c < 25; c++) begin
      tick();
      step_i = (c == 1 || c == 2) ? 1'b1 : 1'b0;
      if ({div_o, dir_o, wren_o, busy_o} !== {exp_div, exp_dir, exp_wren, exp_busy}) begin
        n_err++;
        $display("FAIL holdoff_cycle edge=%0d got %0d/%b/%b/%b want %0d/%b/%b/%b", edge_n - 1,
                 div_o, dir_o, wren_o, busy_o, exp_div, exp_dir, exp_wren, exp_busy);
      end
      n_vec++;
      if (wren_o === 1'b1) wcount++;
    end
    $display("holdoff: %0d strobe(s) for two step presses", wcount);
`ifndef LED_DIV_DEBOUNCE_EN
    if (wcount != 1) begin
      n_err++;
      $display("FAIL holdoff_drop got %0d strobes want 1", wcount);
    end
    n_vec++;
`endif
    // step arriving while dwelling with timer at 3
    do_reset();
    en_i = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (c == 0) step_i = 1'b1;
      if (c == 5) step_i = 1'b0;
      if ({div_o, dir_o, wren_o, busy_o} !== {exp_div, exp_dir, exp_wren, exp_busy}) begin
        n_err++;
        $display("FAIL dwell_step_cycle edge=%0d got %0d/%b/%b/%b want %0d/%b/%b/%b", edge_n - 1,
                 div_o, dir_o, wren_o, busy_o, exp_div, exp_dir, exp_wren, exp_busy);
      end
      n_vec++;
      if (wren_o === 1'b1) w_edge.push_back(edge_n - 1);
    end
    if (w_edge.size() < 2) begin
      n_err++;
      $display("FAIL dwell_step_count got %0d strobes want >=2", w_edge.size());
    end else begin
      $display("dwell step: strobes at edges %0d and %0d", w_edge[0], w_edge[1]);
      if (w_edge[0] != 4 + DBL || (w_edge[1] - w_edge[0]) != 1 + HOLDOFF_CYC + DWELL_CYC) begin
        n_err++;
        $display("FAIL dwell_step_timing got first=%0d gap=%0d want first=%0d gap=%0d",
                 w_edge[0], w_edge[1] - w_edge[0], 4 + DBL, 1 + HOLDOFF_CYC + DWELL_CYC);
      end
    end
    n_vec++;
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    int wcount = 0;
    do_reset();
    en_i = 1'b1;
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      if (wren_o === 1'b1 && div_o === DIV_W'(3)) found = 1'b1;
    end
    if (!found) begin
      n_err++;
      $display("FAIL midreset_setup got no strobe with div=3 within 40 cycles want one");
    end
    n_vec++;
    tick();
    if (busy_o !== 1'b1 || div_o !== DIV_W'(3)) begin
      n_err++;
      $display("FAIL midreset_pre got busy=%b div=%0d want busy=1 div=3", busy_o, div_o);
    end
    n_vec++;
    #3 rst = 1'b1;
    #1;
    if ({div_o, dir_o, wren_o, busy_o} !== {DIV_W'(DIV_MIN), 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL midreset_async got div=%0d dir=%b wren=%b busy=%b want div=%0d dir=1 wren=0 busy=0",
               div_o, dir_o, wren_o, busy_o, DIV_MIN);
    end
    n_vec++;
    en_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk100);
    #1;
    rst = 1'b0;
    repeat (50) begin
      tick();
      if ({div_o, dir_o, wren_o, busy_o} !== {exp_div, exp_dir, exp_wren, exp_busy}) begin
        n_err++;
        $display("FAIL midreset_idle edge=%0d got %0d/%b/%b/%b want %0d/%b/%b/%b", edge_n - 1,
                 div_o, dir_o, wren_o, busy_o, exp_div, exp_dir, exp_wren, exp_busy);
      end
      n_vec++;
      if (wren_o === 1'b1) wcount++;
    end
    if (wcount != 0) begin
      n_err++;
      $display("FAIL midreset_quiet got %0d strobes want 0", wcount);
    end
    n_vec++;
    $display("reset mid-sweep: %0d strobes after release", wcount);
  endtask

  task automatic test_random();
    int en_run = 0;
    int st_run = 0;
    int wcount = 0;
    do_reset();
    repeat (1500) begin
      if (en_run == 0) begin en_i = ~en_i; en_run = int'($urandom_range(5, 60)); end
      if (st_run == 0) begin step_i = ~step_i; st_run = int'($urandom_range(1, 12)); end
      en_run--; st_run--;
      tick();
      if ({div_o, dir_o, wren_o, busy_o} !== {exp_div, exp_dir, exp_wren, exp_busy}) begin
        n_err++;
        $display("FAIL random_cycle edge=%0d got %0d/%b/%b/%b want %0d/%b/%b/%b", edge_n - 1,
                 div_o, dir_o, wren_o, busy_o, exp_div, exp_dir, exp_wren, exp_busy);
      end
      n_vec++;
      if (wren_o === 1'b1) wcount++;
    end
    $display("random: 1500 cycles, %0d strobes", wcount);
  endtask

`ifdef LED_DIV_DEBOUNCE_EN
  task automatic test_debounce();
    int wcount;
    do_reset();
    for (int phase = 0; phase < 2; phase++) begin
      wcount = 0;
      step_i = 1'b1;
      for (int c = 0; c < 30; c++) begin
        tick();
        if (c == ((phase == 0) ? 1 : 7)) step_i = 1'b0;
        if ({div_o, dir_o, wren_o, busy_o} !== {exp_div, exp_dir, exp_wren, exp_busy}) begin
          n_err++;
          $display("FAIL debounce_cycle edge=%0d got %0d/%b/%b/%b want %0d/%b/%b/%b", edge_n - 1,
                   div_o, dir_o, wren_o, busy_o, exp_div, exp_dir, exp_wren, exp_busy);
        end
        n_vec++;
        if (wren_o === 1'b1) wcount++;
      end
      if (wcount != phase) begin
        n_err++;
        $display("FAIL debounce_count phase=%0d got %0d strobes want %0d", phase, wcount, phase);
      end
      n_vec++;
      $display("debounce: press length %0d gave %0d strobe(s)", (phase == 0) ? 2 : 8, wcount);
    end
  endtask
`endif

  initial begin
    #2ms;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_auto_sweep();
    test_manual_step();
    test_step_interactions();
    test_reset_mid();
    test_random();
`ifdef LED_DIV_DEBOUNCE_EN
    test_debounce();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
